fuzz_sched: RTL and testbench

Time-multiplexing scheduler and parameter controller for a single shared `fuzzifier_T` instance. It arbitrates round-robin between `N_CH` crisp-input requesters, such as error and delta-error. It drives the shared fuzzifier with the winner's sample and that channel's active membership-function set, then returns the registered `mu_neg/mu_zero/mu_pos` with channel tag over a valid/ready port. Parameters are double-buffered, shadow then active, and changes take effect only on commit, so an evaluation never sees a half-written set.

---
 rtl/fuzz_sched_if.sv | 48 ++++
 rtl/fuzz_sched.sv | 165 ++++++++++++++++
 tb/tb_fuzz_sched.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fuzz_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fuzz_sched_if
// Purpose  : Request, config, fuzzifier and result bundle of fuzz_sched.
// Revision : 1.0 - initial release
// ============================================================================
interface fuzz_sched_if #(
    parameter int N_CH = 2,
    parameter int CW   = (N_CH <= 2) ? 1 : $clog2(N_CH)
);
    logic [N_CH-1:0]   req_valid;
    logic [8*N_CH-1:0] req_x;
    logic [N_CH-1:0]   req_ready;
    logic              cfg_we;
    logic [CW-1:0]     cfg_ch;
    logic [3:0]        cfg_idx;
    logic [7:0]        cfg_data;
    logic              cfg_commit;
    logic              cfg_err;
    logic [7:0]        fz_x;
    logic [95:0]       fz_par;
    logic [15:0]       fz_mu_neg;
    logic [15:0]       fz_mu_zero;
    logic [15:0]       fz_mu_pos;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_ch;
    logic [15:0]       out_mu_neg;
    logic [15:0]       out_mu_zero;
    logic [15:0]       out_mu_pos;
    logic              busy;

    modport master (
        output req_valid, req_x, cfg_we, cfg_ch, cfg_idx, cfg_data, cfg_commit,
               fz_mu_neg, fz_mu_zero, fz_mu_pos, out_ready,
        input  req_ready, cfg_err, fz_x, fz_par, out_valid, out_ch,
               out_mu_neg, out_mu_zero, out_mu_pos, busy
    );

    modport slave (
        input  req_valid, req_x, cfg_we, cfg_ch, cfg_idx, cfg_data, cfg_commit,
               fz_mu_neg, fz_mu_zero, fz_mu_pos, out_ready,
        output req_ready, cfg_err, fz_x, fz_par, out_valid, out_ch,
               out_mu_neg, out_mu_zero, out_mu_pos, busy
    );
endinterface
`default_nettype wire

// File: rtl/fuzz_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fuzz_sched
// Purpose  : Round-robin time-multiplexer for one shared fuzzifier with
//            double-buffered per-channel membership-function parameters.
// Revision : 1.0 - initial release
// ============================================================================
module fuzz_sched #(
    parameter int N_CH = 2,
    parameter int CW   = (N_CH <= 2) ? 1 : $clog2(N_CH)
) (
    input  logic        clk,
    input  logic        rst_n,
    fuzz_sched_if.slave bus
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_eval = 2'd1;
    localparam logic [1:0]  c_st_hold = 2'd2;
    // idx 0 at LSB: neg(-128,-64,-32,0) zero(-16,0,0,16) pos(0,32,64,127)
    localparam logic [95:0] c_def_par = 96'h7F_40_20_00_10_00_00_F0_00_E0_C0_80;

    logic [1:0]    r_state;
    logic          r_started;
    logic          r_commit_pend;
    logic          r_wr_err;
    logic          r_out_valid;
    logic [CW-1:0] r_rr_ptr;
    logic [CW-1:0] r_ch;
    logic [CW-1:0] r_out_ch;
    logic [7:0]    r_fz_x;
    logic [95:0]   r_fz_par;
    logic [15:0]   r_out_mu_neg;
    logic [15:0]   r_out_mu_zero;
    logic [15:0]   r_out_mu_pos;
    logic [95:0]   r_shadow [N_CH];
    logic [95:0]   r_active [N_CH];

    logic [CW-1:0] w_gidx;
    logic          w_found;
    logic          w_grant;
    logic          w_apply;
    logic          w_bank_ok;
    logic          w_cfg_ok;
    logic          w_cfg_wr;

    function automatic logic [15:0] f_clamp(input logic [15:0] v);
        return (v > 16'h7FFF) ? 16'h7FFF : v;
    endfunction

    assign w_cfg_ok = (bus.cfg_idx <= 4'd11) && (int'(bus.cfg_ch) < N_CH);
    assign w_cfg_wr = bus.cfg_we && w_cfg_ok;
    assign w_apply  = (r_state == c_st_idle) && r_commit_pend;
    assign w_grant  = (r_state == c_st_idle) && r_started && !r_commit_pend && w_found;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!w_found && bus.req_valid[(int'(r_rr_ptr) + k) % N_CH]) begin
                w_found = 1'b1;
                w_gidx  = CW'((int'(r_rr_ptr) + k) % N_CH);
            end
        end
    end

    // Every MF of every channel must be ordered a<=b<=c<=d (signed) to commit.
    always_comb begin
        w_bank_ok = 1'b1;
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int m = 0; m < 3; m++) begin
                if (($signed(r_shadow[ch][32*m +: 8])      > $signed(r_shadow[ch][32*m + 8 +: 8]))  ||
                    ($signed(r_shadow[ch][32*m + 8 +: 8])  > $signed(r_shadow[ch][32*m + 16 +: 8])) ||
                    ($signed(r_shadow[ch][32*m + 16 +: 8]) > $signed(r_shadow[ch][32*m + 24 +: 8])))
                    w_bank_ok = 1'b0;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_grant)
            bus.req_ready[w_gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                r_shadow[ch] <= c_def_par;
                r_active[ch] <= c_def_par;
            end
        end else begin
            if (w_cfg_wr)
                r_shadow[bus.cfg_ch][8*bus.cfg_idx +: 8] <= bus.cfg_data;
            if (w_apply && w_bank_ok)
                r_active <= r_shadow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_started     <= 1'b0;
            r_commit_pend <= 1'b0;
            r_wr_err      <= 1'b0;
            r_rr_ptr      <= '0;
            r_ch          <= '0;
            r_fz_x        <= '0;
            r_fz_par      <= '0;
            r_out_valid   <= 1'b0;
            r_out_ch      <= '0;
            r_out_mu_neg  <= '0;
            r_out_mu_zero <= '0;
            r_out_mu_pos  <= '0;
        end else begin
            r_started <= 1'b1;
            r_wr_err  <= bus.cfg_we && !w_cfg_ok;
            if (bus.cfg_commit)
                r_commit_pend <= 1'b1;
            else if (w_apply)
                r_commit_pend <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        r_ch     <= w_gidx;
                        r_fz_x   <= bus.req_x[8*w_gidx +: 8];
                        r_fz_par <= r_active[w_gidx];
                        r_rr_ptr <= (int'(w_gidx) == N_CH - 1) ? '0 : w_gidx + 1'b1;
                        r_state  <= c_st_eval;
                    end
                end
                c_st_eval: begin
                    r_out_mu_neg  <= f_clamp(bus.fz_mu_neg);
                    r_out_mu_zero <= f_clamp(bus.fz_mu_zero);
                    r_out_mu_pos  <= f_clamp(bus.fz_mu_pos);
                    r_out_ch      <= r_ch;
                    r_out_valid   <= 1'b1;
                    r_state       <= c_st_hold;
                end
                c_st_hold: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // A rejected commit is reported in the very cycle it is evaluated.
    assign bus.cfg_err     = r_wr_err | (w_apply & ~w_bank_ok);
    assign bus.fz_x        = r_fz_x;
    assign bus.fz_par      = r_fz_par;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_ch      = r_out_ch;
    assign bus.out_mu_neg  = r_out_mu_neg;
    assign bus.out_mu_zero = r_out_mu_zero;
    assign bus.out_mu_pos  = r_out_mu_pos;
    assign bus.busy        = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_fuzz_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fuzz_sched
// Purpose  : Directed scoreboard bench for fuzz_sched with a trapezoid
//            fuzzifier model and a reference parameter-bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fuzz_sched;
    localparam int N_CH = 2;
    localparam int CW   = 1;
    localparam int c_def [12] = '{-128, -64, -32, 0, -16, 0, 0, 16, 0, 32, 64, 127};

    typedef struct {
        logic [CW-1:0] ch;
        logic [15:0]   neg;
        logic [15:0]   zero;
        logic [15:0]   pos;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fuzz_sched_if #(.N_CH(N_CH), .CW(CW)) bus ();
    fuzz_sched #(.N_CH(N_CH), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_results = 0;
    int   last_grant = -1;
    bit   chk_spacing = 1'b0;
    int   m_shadow [N_CH][12];
    int   m_active [N_CH][12];
    int   m_rr;
    int   mon_g, mon_exp_g, mon_x;

    function automatic int f_mu(input int x, input int a, input int b, input int c, input int d);
        if (x >= b && x <= c) return 32768;
        if (x <= a || x >= d) return 0;
        if (x < b) return (x - a) * 32768 / (b - a);
        return (d - x) * 32768 / (d - c);
    endfunction

    function automatic int f_clampi(input int v);
        return (v > 32767) ? 32767 : v;
    endfunction

    function automatic logic [15:0] f_fz(input logic [7:0] x, input logic [95:0] p, input int m);
        return 16'(f_mu($signed(x), $signed(p[32*m +: 8]), $signed(p[32*m + 8 +: 8]),
                        $signed(p[32*m + 16 +: 8]), $signed(p[32*m + 24 +: 8])));
    endfunction

    // Stand-in for the shared combinational fuzzifier.
    assign bus.fz_mu_neg  = f_fz(bus.fz_x, bus.fz_par, 0);
    assign bus.fz_mu_zero = f_fz(bus.fz_x, bus.fz_par, 1);
    assign bus.fz_mu_pos  = f_fz(bus.fz_x, bus.fz_par, 2);

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++)
            for (int k = 0; k < 12; k++) begin
                m_shadow[ch][k] = c_def[k];
                m_active[ch][k] = c_def[k];
            end
        m_rr = 0;
    endtask

    task automatic model_commit();
        bit ok;
        ok = 1'b1;
        for (int ch = 0; ch < N_CH; ch++)
            for (int m = 0; m < 3; m++)
                if (!(m_shadow[ch][4*m] <= m_shadow[ch][4*m+1] &&
                      m_shadow[ch][4*m+1] <= m_shadow[ch][4*m+2] &&
                      m_shadow[ch][4*m+2] <= m_shadow[ch][4*m+3]))
                    ok = 1'b0;
        if (ok)
            for (int ch = 0; ch < N_CH; ch++)
                for (int k = 0; k < 12; k++)
                    m_active[ch][k] = m_shadow[ch][k];
    endtask

    task automatic cfg_write(input int ch, input int idx, input int data, input bit commit);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = CW'(ch);
        bus.cfg_idx    = 4'(idx);
        bus.cfg_data   = 8'(data);
        bus.cfg_commit = commit;
        if (idx <= 11 && ch < N_CH) m_shadow[ch][idx] = data;
        if (commit) model_commit();
        tick();
        bus.cfg_we     = 1'b0;
        bus.cfg_commit = 1'b0;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return bus.busy === 1'b1;
            1:       return bus.out_valid === 1'b1;
            2:       return bus.busy === 1'b0 && bus.out_valid === 1'b0;
            default: return bus.cfg_err === 1'b1;
        endcase
    endfunction

    task automatic wait_cond(input int which, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (cond(which)) break;
            tick();
        end
        check(tag, cond(which), 1'b1);
    endtask

    // Monitor: arbitration check and scoreboard push on grant, pop on result.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((bus.req_valid & bus.req_ready) != '0) begin
                mon_g = 0;
                for (int i = 0; i < N_CH; i++) if (bus.req_ready[i]) mon_g = i;
                mon_exp_g = -1;
                for (int k = 0; k < N_CH; k++)
                    if (mon_exp_g < 0 && bus.req_valid[(m_rr + k) % N_CH]) mon_exp_g = (m_rr + k) % N_CH;
                check("grant_onehot", $countones(bus.req_ready), 1);
                check("grant_ch", mon_g, mon_exp_g);
                if (chk_spacing && last_grant >= 0) check("grant_gap", cyc - last_grant, 3);
                last_grant = cyc;
                m_rr  = (mon_g + 1) % N_CH;
                mon_x = $signed(bus.req_x[8*mon_g +: 8]);
                mon_e.ch   = CW'(mon_g);
                mon_e.neg  = 16'(f_clampi(f_mu(mon_x, m_active[mon_g][0], m_active[mon_g][1], m_active[mon_g][2], m_active[mon_g][3])));
                mon_e.zero = 16'(f_clampi(f_mu(mon_x, m_active[mon_g][4], m_active[mon_g][5], m_active[mon_g][6], m_active[mon_g][7])));
                mon_e.pos  = 16'(f_clampi(f_mu(mon_x, m_active[mon_g][8], m_active[mon_g][9], m_active[mon_g][10], m_active[mon_g][11])));
                sb.push_back(mon_e);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_has_entry", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("sb_ch", bus.out_ch, mon_e.ch);
                    check("sb_mu_neg", bus.out_mu_neg, mon_e.neg);
                    check("sb_mu_zero", bus.out_mu_zero, mon_e.zero);
                    check("sb_mu_pos", bus.out_mu_pos, mon_e.pos);
                end
                n_results++;
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_x      = {8'd8, 8'hD0};
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_idx    = '0;
        bus.cfg_data   = '0;
        bus.cfg_commit = 1'b0;
        bus.out_ready  = 1'b1;
        model_reset();
        repeat (2) tick();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_fz_x", bus.fz_x, 0);
        check("rst_fz_par", bus.fz_par, 0);
        check("rst_out_mu", {bus.out_ch, bus.out_mu_neg, bus.out_mu_zero, bus.out_mu_pos}, 0);
        check("rst_req_ready", bus.req_ready, 0);

        // Defaults: ch0 x=-48, ch1 x=8, both valid, then fairness run.
        rst_n = 1'b1;
        #1;
        check("ready_first_cycle", bus.req_ready, 2'b00);
        chk_spacing = 1'b1;
        last_grant  = -1;
        tick();
        check("ready_ch0_first", bus.req_ready, 2'b01);
        tick();
        check("eval_busy", bus.busy, 1);
        check("eval_no_valid", bus.out_valid, 0);
        tick();
        check("def_ch0_valid", bus.out_valid, 1);
        check("def_ch0_result", {bus.out_ch, bus.out_mu_neg, bus.out_mu_zero, bus.out_mu_pos},
              {1'b0, 16'h7FFF, 16'h0000, 16'h0000});
        repeat (3) tick();
        check("def_ch1_result", {bus.out_ch, bus.out_mu_neg, bus.out_mu_zero, bus.out_mu_pos},
              {1'b1, 16'h0000, 16'd16384, 16'd8192});
        for (int i = 0; i < 100 && n_results < 8; i++) tick();
        check("fair_8_results", n_results >= 8, 1'b1);
        chk_spacing = 1'b0;
        bus.req_valid = 2'b00;
        wait_cond(2, "fair_idle");

        // Backpressure: result held for 5 cycles with ch1 waiting.
        bus.out_ready = 1'b0;
        bus.req_valid = 2'b01;
        wait_cond(0, "bp_busy");
        bus.req_valid = 2'b10;
        wait_cond(1, "bp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {bus.out_valid, bus.busy, bus.req_ready, bus.out_ch, bus.out_mu_neg},
                  {1'b1, 1'b1, 2'b00, 1'b0, 16'h7FFF});
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_idle", {bus.out_valid, bus.busy, bus.req_ready}, {1'b0, 1'b0, 2'b10});
        tick();
        bus.req_valid = 2'b00;
        wait_cond(2, "bp_drain");

        // Commit during HOLD: in-flight ch1 result keeps the old zero set.
        bus.out_ready = 1'b0;
        bus.req_valid = 2'b10;
        wait_cond(0, "ch_busy");
        bus.req_valid = 2'b00;
        wait_cond(1, "ch_valid");
        cfg_write(1, 4, -25, 1'b0);
        cfg_write(1, 5, -5, 1'b0);
        cfg_write(1, 6, -5, 1'b0);
        cfg_write(1, 7, 25, 1'b1);
        check("ch_inflight_old", {bus.busy, bus.out_valid, bus.out_mu_zero}, {1'b1, 1'b1, 16'd16384});
        bus.req_x     = {8'hF1, 8'hD0};
        bus.req_valid = 2'b10;
        bus.out_ready = 1'b1;
        tick();
        check("ch_commit_cycle", {bus.busy, bus.req_ready, bus.cfg_err}, {1'b0, 2'b00, 1'b0});
        tick();
        check("ch_grant_after", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        tick();
        check("ch_new_set", {bus.out_valid, bus.out_ch, bus.out_mu_zero}, {1'b1, 1'b1, 16'd16384});
        wait_cond(2, "ch_drain");

        // Rejected commit: b_neg=-20 breaks ordering on ch0.
        cfg_write(0, 1, -20, 1'b1);
        wait_cond(3, "rej_err_pulse");
        tick();
        check("rej_err_clear", bus.cfg_err, 0);
        bus.req_x     = {8'd8, 8'hD0};
        bus.req_valid = 2'b01;
        wait_cond(0, "rej_busy");
        bus.req_valid = 2'b00;
        wait_cond(1, "rej_valid");
        check("rej_old_bank", {bus.out_ch, bus.out_mu_neg}, {1'b0, 16'h7FFF});
        wait_cond(2, "rej_drain");
        cfg_write(0, 12, 5, 1'b0);
        check("idx12_err", bus.cfg_err, 1);
        tick();
        check("idx12_err_clear", bus.cfg_err, 0);

        // Reset mid-EVAL.
        bus.req_valid = 2'b01;
        wait_cond(0, "rst_eval_busy");
        bus.req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("rst_abort", {bus.out_valid, bus.busy, bus.req_ready, bus.cfg_err, bus.fz_x, bus.fz_par},
              {1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 96'h0});
        check("rst_abort_out", {bus.out_ch, bus.out_mu_neg, bus.out_mu_zero, bus.out_mu_pos}, 0);
        sb.delete();
        model_reset();
        tick();
        tick();
        bus.req_valid = 2'b11;
        rst_n = 1'b1;
        tick();
        check("rst_rr_ptr", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b10;
        for (int i = 0; i < 20 && !(bus.out_valid === 1'b1 && bus.out_ch === 1'b1); i++) tick();
        check("rst_bank_default", {bus.out_valid, bus.out_ch, bus.out_mu_zero}, {1'b1, 1'b1, 16'd16384});
        bus.req_valid = 2'b00;
        wait_cond(2, "final_drain");
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
